// File: rtl/acc_pkg.sv
// Shared types and helpers for the streaming vector accumulator.
package acc_pkg;

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_ACCUM,
      ACC_HOLD
   } acc_state_e;

   // Highest set bit of the lane count; a lane count of zero behaves as one lane.
   function automatic logic [2:0] lanes_to_shift(input logic [4:0] lanes);
      if (lanes[4])      return 3'd4;
      else if (lanes[3]) return 3'd3;
      else if (lanes[2]) return 3'd2;
      else if (lanes[1]) return 3'd1;
      else               return 3'd0;
   endfunction

   // Clamp value in the low 'width' bits: unsigned all-ones, signed max or min.
   function automatic logic [63:0] sat_limit(input int unsigned width,
                                             input logic        is_signed,
                                             input logic        neg);
      logic [63:0] one;
      one = 64'd1;
      if (!is_signed) return (one << width) - one;
      else if (neg)   return one << (width - 1);
      else            return (one << (width - 1)) - one;
   endfunction

endpackage

// File: rtl/accumulator_stream_if.sv
// Config, input-beat and result handshake bundle for accumulator_stream.
interface accumulator_stream_if #(
   parameter int W_LEN = 13,
   parameter int W_IN  = 20,
   parameter int W_ACC = 32
);
   logic             cfg_start;
   logic [W_LEN-1:0] cfg_elems;
   logic [4:0]       cfg_lanes;
   logic             cfg_signed;
   logic             cfg_sat;
   logic             in_valid;
   logic             in_ready;
   logic [W_IN-1:0]  partial_sum;
   logic             out_valid;
   logic             out_ready;
   logic [W_ACC-1:0] final_sum;
   logic             overflow;
   logic             busy;

   modport master (
      output cfg_start, cfg_elems, cfg_lanes, cfg_signed, cfg_sat,
      output in_valid, partial_sum, out_ready,
      input  in_ready, out_valid, final_sum, overflow, busy
   );

   modport slave (
      input  cfg_start, cfg_elems, cfg_lanes, cfg_signed, cfg_sat,
      input  in_valid, partial_sum, out_ready,
      output in_ready, out_valid, final_sum, overflow, busy
   );
endinterface

// File: rtl/acc_add_sat.sv
// Combinational extend-add with overflow detection and optional saturation.
module acc_add_sat
   import acc_pkg::*;
#(
   parameter int W_IN  = 20,
   parameter int W_ACC = 32
) (
   input  logic [W_ACC-1:0] acc_i,
   input  logic [W_IN-1:0]  ps_i,
   input  logic             signed_i,
   input  logic             sat_i,
   output logic [W_ACC-1:0] sum_o,
   output logic             ovf_o
);

   logic [W_ACC:0] acc_x;
   logic [W_ACC:0] ps_x;
   logic [W_ACC:0] sum_x;

   // NOTE: one guard bit keeps the true result's carry (unsigned) or sign (signed).
   assign acc_x = signed_i ? {acc_i[W_ACC-1], acc_i} : {1'b0, acc_i};
   assign ps_x  = signed_i ? {{(W_ACC + 1 - W_IN){ps_i[W_IN-1]}}, ps_i}
                           : {{(W_ACC + 1 - W_IN){1'b0}}, ps_i};
   assign sum_x = acc_x + ps_x;

   assign ovf_o = signed_i ? (sum_x[W_ACC] ^ sum_x[W_ACC-1]) : sum_x[W_ACC];
   assign sum_o = (ovf_o && sat_i) ? W_ACC'(sat_limit(W_ACC, signed_i, sum_x[W_ACC]))
                                   : sum_x[W_ACC-1:0];

endmodule

// File: rtl/accumulator_stream.sv
// Vector accumulator: sums ceil(elems/lanes) beats, then holds the result until taken.
module accumulator_stream
   import acc_pkg::*;
#(
   parameter int MAX_ELEMS = 4096,
   parameter int W_IN      = 20,
   parameter int W_ACC     = 32,
   parameter int W_LEN     = $clog2(MAX_ELEMS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   accumulator_stream_if.slave  bus
);

   localparam logic [W_LEN:0]   ROUND_ONE = 1;
   localparam logic [W_LEN-1:0] BEAT_ONE  = 1;

   acc_state_e       state_q;
   logic [W_LEN-1:0] beats_q;
   logic [W_LEN-1:0] beats_d;
   logic             signed_q;
   logic             sat_q;
   logic             ovf_q;
   logic [W_ACC-1:0] acc_q;
   logic [W_ACC-1:0] acc_d;
   logic             ovf_d;
   logic [2:0]       shift;
   logic [W_LEN:0]   round_up;
   logic             start_ok;

   assign shift    = lanes_to_shift(bus.cfg_lanes);
   assign round_up = {1'b0, bus.cfg_elems} + (ROUND_ONE << shift) - ROUND_ONE;
   assign beats_d  = W_LEN'(round_up >> shift);

   // A new vector opens from IDLE, or from HOLD in the same cycle the result is taken.
   assign start_ok = bus.cfg_start &&
                     ((state_q == ACC_IDLE) || ((state_q == ACC_HOLD) && bus.out_ready));

   acc_add_sat #(
      .W_IN  (W_IN),
      .W_ACC (W_ACC)
   ) u_add_sat (
      .acc_i    (acc_q),
      .ps_i     (bus.partial_sum),
      .signed_i (signed_q),
      .sat_i    (sat_q),
      .sum_o    (acc_d),
      .ovf_o    (ovf_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ACC_IDLE;
         beats_q  <= '0;
         signed_q <= 1'b0;
         sat_q    <= 1'b0;
         acc_q    <= '0;
         ovf_q    <= 1'b0;
      end else if (start_ok) begin
         signed_q <= bus.cfg_signed;
         sat_q    <= bus.cfg_sat;
         acc_q    <= '0;
         ovf_q    <= 1'b0;
         beats_q  <= beats_d;
         state_q  <= (beats_d == '0) ? ACC_HOLD : ACC_ACCUM;
      end else begin
         case (state_q)
            ACC_ACCUM: begin
               if (bus.in_valid) begin
                  acc_q   <= acc_d;
                  ovf_q   <= ovf_q | ovf_d;
                  beats_q <= beats_q - BEAT_ONE;
                  if (beats_q == BEAT_ONE) state_q <= ACC_HOLD;
               end
            end
            ACC_HOLD: begin
               if (bus.out_ready) state_q <= ACC_IDLE;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == ACC_ACCUM);
   assign bus.out_valid = (state_q == ACC_HOLD);
   assign bus.busy      = (state_q != ACC_IDLE);
   assign bus.final_sum = acc_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_accumulator_stream.sv
// Randomised bench for accumulator_stream (32- and 24-bit accumulators) against a reference model.
module tb_accumulator_stream;

   localparam int W_IN  = 20;
   localparam int W_LEN = 13;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   accumulator_stream_if #(.W_LEN(W_LEN), .W_IN(W_IN), .W_ACC(32)) bus32 ();
   accumulator_stream_if #(.W_LEN(W_LEN), .W_IN(W_IN), .W_ACC(24)) bus24 ();

   accumulator_stream #(.MAX_ELEMS(4096), .W_IN(W_IN), .W_ACC(32)) dut32 (
      .clk (clk), .rst_n (rst_n), .bus (bus32)
   );
   accumulator_stream #(.MAX_ELEMS(4096), .W_IN(W_IN), .W_ACC(24)) dut24 (
      .clk (clk), .rst_n (rst_n), .bus (bus24)
   );

   // One set of drive variables, steered to the selected DUT.
   bit               sel;
   logic             cfg_start, in_valid, out_ready, cfg_signed, cfg_sat;
   logic [W_LEN-1:0] cfg_elems;
   logic [4:0]       cfg_lanes;
   logic [W_IN-1:0]  partial_sum;

   assign bus32.cfg_start   = cfg_start & ~sel;
   assign bus32.in_valid    = in_valid  & ~sel;
   assign bus32.out_ready   = out_ready & ~sel;
   assign bus24.cfg_start   = cfg_start & sel;
   assign bus24.in_valid    = in_valid  & sel;
   assign bus24.out_ready   = out_ready & sel;
   assign bus32.cfg_elems   = cfg_elems;
   assign bus24.cfg_elems   = cfg_elems;
   assign bus32.cfg_lanes   = cfg_lanes;
   assign bus24.cfg_lanes   = cfg_lanes;
   assign bus32.cfg_signed  = cfg_signed;
   assign bus24.cfg_signed  = cfg_signed;
   assign bus32.cfg_sat     = cfg_sat;
   assign bus24.cfg_sat     = cfg_sat;
   assign bus32.partial_sum = partial_sum;
   assign bus24.partial_sum = partial_sum;

   logic        o_in_ready, o_out_valid, o_overflow, o_busy;
   logic [31:0] o_sum;
   assign o_in_ready  = sel ? bus24.in_ready  : bus32.in_ready;
   assign o_out_valid = sel ? bus24.out_valid : bus32.out_valid;
   assign o_overflow  = sel ? bus24.overflow  : bus32.overflow;
   assign o_busy      = sel ? bus24.busy      : bus32.busy;
   assign o_sum       = sel ? {8'h00, bus24.final_sum} : bus32.final_sum;

   int hs_cnt = 0;
   always @(posedge clk)
      if (sel ? (bus24.in_valid && bus24.in_ready) : (bus32.in_valid && bus32.in_ready))
         hs_cnt <= hs_cnt + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int lanes_of(input logic [4:0] lanes);
      int l;
      l = 1;
      for (int b = 0; b < 5; b++) if (lanes[b]) l = 1 << b;
      return l;
   endfunction

   // Exact integer sum, then range check and clamp/wrap into a w-bit accumulator.
   function automatic longint ref_step(input int w, input bit sgn, input bit sat,
                                       input longint acc, input logic [W_IN-1:0] ps,
                                       inout bit ovf);
      longint m, v, t, hi, lo;
      m = longint'(1) << w;
      if (sgn) v = longint'($signed(ps));
      else     v = longint'({44'd0, ps});
      t  = acc + v;
      hi = sgn ? (m / 2 - 1) : (m - 1);
      lo = sgn ? -(m / 2) : 0;
      if (t > hi || t < lo) begin
         ovf = 1'b1;
         if (sat) t = (t > hi) ? hi : lo;
         else begin
            t = t & (m - 1);
            if (sgn && t > hi) t = t - m;
         end
      end
      return t;
   endfunction

   // Caller is at a negedge; cfg_start is raised here and the vector runs to HOLD.
   task automatic run_vec(input int elems, input logic [4:0] lanes, input bit sgn, input bit sat,
                          input bit rnd, input logic [W_IN-1:0] cval, input int gap,
                          input int hold, input string tag);
      int w, beats, sent, cyc, hs0;
      longint acc;
      bit ovf, bad;
      logic [W_IN-1:0] d;
      logic [63:0] mask;
      logic [31:0] fs;
      logic ov;
      w     = sel ? 24 : 32;
      mask  = (64'd1 << w) - 64'd1;
      beats = (elems + lanes_of(lanes) - 1) / lanes_of(lanes);
      cfg_start  = 1'b1;
      cfg_elems  = W_LEN'(elems);
      cfg_lanes  = lanes;
      cfg_signed = sgn;
      cfg_sat    = sat;
      hs0 = hs_cnt;
      @(negedge clk);
      cfg_start = 1'b0;
      out_ready = 1'b0;
      check({tag, "/rdy_start"}, o_in_ready, beats > 0);
      check({tag, "/busy"}, o_busy, 1);
      acc = 0; ovf = 1'b0; sent = 0; cyc = 0;
      while (sent < beats && cyc < beats * 4 + 64) begin
         d = rnd ? W_IN'($urandom) : cval;
         in_valid    = ($urandom_range(0, 99) >= gap);
         partial_sum = d;
         if (in_valid && o_in_ready) begin
            acc = ref_step(w, sgn, sat, acc, d, ovf);
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      if (sent < beats) check({tag, "/timeout"}, sent, beats);
      check({tag, "/handshakes"}, hs_cnt - hs0, beats);
      check({tag, "/out_valid"}, o_out_valid, 1);
      check({tag, "/rdy_hold"}, o_in_ready, 0);
      check({tag, "/sum"}, o_sum, 64'(acc) & mask);
      check({tag, "/ovf"}, o_overflow, ovf);
      bad = 1'b0;
      fs  = o_sum;
      ov  = o_overflow;
      for (int i = 0; i < hold; i++) begin
         cfg_start = 1'b1;
         in_valid  = 1'b1;
         @(negedge clk);
         if (o_out_valid !== 1'b1 || o_sum !== fs || o_overflow !== ov || o_in_ready !== 1'b0)
            bad = 1'b1;
      end
      cfg_start = 1'b0;
      in_valid  = 1'b0;
      if (hold > 0) check({tag, "/hold_stable"}, bad, 0);
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "/drained"}, o_out_valid, 0);
      check({tag, "/idle"}, o_busy, 0);
   endtask

   initial begin
      logic [4:0] lane_tab [5];
      lane_tab = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
      sel = 1'b0;
      cfg_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      cfg_signed = 1'b0; cfg_sat = 1'b0; cfg_elems = '0; cfg_lanes = '0; partial_sum = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst/in_ready", o_in_ready, 0);
      check("rst/out_valid", o_out_valid, 0);
      check("rst/final_sum", o_sum, 0);
      check("rst/overflow", o_overflow, 0);
      check("rst/busy", o_busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_vec(1000, 5'd1, 0, 0, 0, 20'hFFFFF, 0, 0, "u_wrap_fffff");
      check("u_wrap_fffff/const", o_sum, 64'd1048575000);
      drain("u_wrap_fffff");

      for (int k = 0; k < 5; k++) begin
         run_vec(1000, lane_tab[k], 0, 0, 0, 20'd1, 20, 0, "lanes_ones");
         drain("lanes_ones");
         run_vec($urandom_range(1, 1000), lane_tab[k], $urandom_range(0, 1), $urandom_range(0, 1),
                 1, '0, 25, 0, "lanes_rand");
         drain("lanes_rand");
      end

      run_vec(4, 5'd1, 1, 0, 0, 20'h80000, 0, 0, "s_neg");
      check("s_neg/const", o_sum, 64'hFFE00000);
      drain("s_neg");

      run_vec(4096, 5'd1, 0, 1, 0, 20'hFFFFF, 0, 0, "max_elems");
      drain("max_elems");

      sel = 1'b1;
      run_vec(17, 5'd1, 0, 1, 0, 20'hFFFFF, 0, 0, "w24_sat");
      check("w24_sat/const", o_sum, 64'hFFFFFF);
      drain("w24_sat");
      run_vec(17, 5'd1, 0, 0, 0, 20'hFFFFF, 0, 0, "w24_wrap");
      check("w24_wrap/const", o_sum, 64'h0FFFEF);
      drain("w24_wrap");
      for (int k = 0; k < 8; k++) begin
         run_vec($urandom_range(1, 200), 5'($urandom_range(0, 31)), $urandom_range(0, 1),
                 $urandom_range(0, 1), 1, '0, 20, 0, "w24_rand");
         drain("w24_rand");
      end
      sel = 1'b0;

      run_vec(37, 5'd4, 0, 0, 1, '0, 10, 10, "hold");
      out_ready = 1'b1;
      run_vec(100, 5'd2, 1, 1, 1, '0, 10, 0, "chain");
      drain("chain");

      run_vec(0, 5'd8, 0, 0, 0, '0, 0, 0, "elems0");
      drain("elems0");

      cfg_start = 1'b1; cfg_elems = 13'd200; cfg_lanes = 5'd1; cfg_signed = 1'b0; cfg_sat = 1'b0;
      @(negedge clk);
      cfg_start = 1'b0; in_valid = 1'b1; partial_sum = 20'd5;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst/in_ready", o_in_ready, 0);
      check("mid_rst/out_valid", o_out_valid, 0);
      check("mid_rst/final_sum", o_sum, 0);
      check("mid_rst/overflow", o_overflow, 0);
      check("mid_rst/busy", o_busy, 0);
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      run_vec(50, 5'd1, 0, 0, 1, '0, 15, 0, "after_rst");
      drain("after_rst");

      for (int k = 0; k < 6; k++) begin
         run_vec($urandom_range(0, 4096), 5'($urandom_range(0, 31)), $urandom_range(0, 1),
                 $urandom_range(0, 1), 1, '0, 30, 0, "w32_rand");
         drain("w32_rand");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
